// File: rtl/libalu.sv
// libalu: shared ALU encodings plus the multiply sequencer's state and watchdog constants.
package libalu;
   localparam logic [2:0] F3_MULL   = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;
   localparam logic [5:0]  WD_LIMIT  = 6'd40;
   localparam logic [31:0] WD_RESULT = 32'hDEADBEEF;
endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: issue/writeback sequencer driving an external multiplier,
// with zero-operand bypass, watchdog timeout and pipeline flush.
module muldiv_seq
   import libalu::*;
#(
   parameter bit ZERO_SKIP = 1'b1,
   parameter int RD_W      = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      req_funct3_i,
   input  logic [31:0]     req_a_i,
   input  logic [31:0]     req_b_i,
   input  logic [RD_W-1:0] req_rd_i,
   input  logic            flush_i,
   output logic            mul_en_o,
   output logic [2:0]      mul_funct3_o,
   output logic [31:0]     mul_a_o,
   output logic [31:0]     mul_b_o,
   input  logic            mul_finish_i,
   input  logic [31:0]     mul_result_i,
   output logic            alu_share_o,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [31:0]     rsp_data_o,
   output logic [RD_W-1:0] rsp_rd_o,
   output logic            busy_o
);
   state_t          state;
   logic [2:0]      f3;
   logic [31:0]     a, b, res;
   logic [RD_W-1:0] rd;
   logic [5:0]      wd;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= S_IDLE;
         f3    <= '0;
         a     <= '0;
         b     <= '0;
         rd    <= '0;
         res   <= '0;
         wd    <= '0;
      end else if (flush_i) state <= S_IDLE;
      else case (state)
         S_IDLE: if (req_valid_i) begin
            f3 <= req_funct3_i;
            a  <= req_a_i;
            b  <= req_b_i;
            rd <= req_rd_i;
            wd <= '0;
            if (ZERO_SKIP && (req_a_i == '0 || req_b_i == '0)) begin
               res   <= '0;
               state <= S_DONE;
            end else state <= S_RUN;
         end
         S_RUN: begin
            wd <= wd + 6'd1;
            // a real completion wins over a timeout landing in the same cycle
            if (mul_finish_i) begin
               res   <= mul_result_i;
               state <= S_DONE;
            end else if (wd == WD_LIMIT - 6'd1) begin
               res   <= WD_RESULT;
               state <= S_DONE;
            end
         end
         S_DONE: if (rsp_ready_i) state <= S_IDLE;
         default: state <= S_IDLE;
      endcase

   assign req_ready_o  = state == S_IDLE;
   assign mul_en_o     = state == S_RUN;
   assign alu_share_o  = state == S_RUN;
   assign rsp_valid_o  = state == S_DONE;
   assign busy_o       = state != S_IDLE;
   assign mul_funct3_o = f3;
   assign mul_a_o      = a;
   assign mul_b_o      = b;
   assign rsp_data_o   = res;
   assign rsp_rd_o     = rd;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against a behavioural
// multiply model, with a 33-cycle external multiplier modelled in the bench.
module tb_muldiv_seq;
   import libalu::*;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [2:0]  req_funct3_i = '0;
   logic [31:0] req_a_i = '0;
   logic [31:0] req_b_i = '0;
   logic [4:0]  req_rd_i = '0;
   logic        flush_i = 1'b0;
   logic        mul_en_o;
   logic [2:0]  mul_funct3_o;
   logic [31:0] mul_a_o, mul_b_o;
   logic        mul_finish_i;
   logic [31:0] mul_result_i;
   logic        alu_share_o;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_data_o;
   logic [4:0]  rsp_rd_o;
   logic        busy_o;
   logic        stall_mul = 1'b0;
   int          mcnt = 0;
   int          vectors = 0;
   int          miscompares = 0;

   muldiv_seq dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_funct3_i(req_funct3_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rd_i(req_rd_i),
      .flush_i(flush_i),
      .mul_en_o(mul_en_o), .mul_funct3_o(mul_funct3_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
      .mul_finish_i(mul_finish_i), .mul_result_i(mul_result_i),
      .alu_share_o(alu_share_o),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      longint xs, ys, p;
      xs = (f == F3_MULH || f == F3_MULHSU) ? longint'($signed(x)) : longint'({32'b0, x});
      ys = (f == F3_MULH) ? longint'($signed(y)) : longint'({32'b0, y});
      p  = xs * ys;
      return (f == F3_MULL) ? p[31:0] : p[63:32];
   endfunction

   // external multiplier: finishes on its 33rd enabled cycle unless stalled
   always @(posedge clk) mcnt <= mul_en_o ? mcnt + 1 : 0;
   assign mul_finish_i = mul_en_o && mcnt == 32 && !stall_mul;
   assign mul_result_i = ref_mul(mul_funct3_o, mul_a_o, mul_b_o);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      req_valid_i  = 1'b1;
      req_funct3_i = f;
      req_a_i      = a;
      req_b_i      = b;
      req_rd_i     = rd;
      tick();
      req_valid_i  = 1'b0;
      req_a_i      = $urandom;
      req_b_i      = $urandom;
   endtask

   // full operation: accept, wait for response, hold off ready, then complete handshake
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold, input bit timeout);
      int lat, en_cnt, rdy_hi, f3_bad;
      bit zero;
      logic [31:0] exp;
      int exp_lat;
      zero    = (a == 0 || b == 0);
      exp     = zero ? 32'd0 : timeout ? 32'hDEADBEEF : ref_mul(f, a, b);
      exp_lat = zero ? 1 : timeout ? 41 : 34;
      stall_mul = timeout;
      chk("ready_before", {31'b0, req_ready_o}, 32'd1);
      issue(f, a, b, rd);
      lat = 1; en_cnt = 0; rdy_hi = 0; f3_bad = 0;
      while (!rsp_valid_o && lat < 100) begin
         if (mul_en_o) en_cnt++;
         if (req_ready_o) rdy_hi++;
         if (mul_en_o && (mul_funct3_o != f || !alu_share_o || !busy_o)) f3_bad++;
         tick();
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("en_cycles", en_cnt, exp_lat - 1);
      chk("ready_low", rdy_hi, 0);
      chk("run_ctrl", f3_bad, 0);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
         chk("hold_data", rsp_data_o, exp);
         chk("hold_rd", {27'b0, rsp_rd_o}, {27'b0, rd});
      end
      chk("data", rsp_data_o, exp);
      chk("rd", {27'b0, rsp_rd_o}, {27'b0, rd});
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      chk("post_valid", {31'b0, rsp_valid_o}, 32'd0);
      chk("post_ready", {31'b0, req_ready_o}, 32'd1);
      stall_mul = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
      chk("rst_en", {31'b0, mul_en_o}, 32'd0);
      chk("rst_share", {31'b0, alu_share_o}, 32'd0);
      chk("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_data", rsp_data_o, 32'd0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      do_op(F3_MULL, 32'd7, 32'd6, 5'd3, 0, 1'b0);
      do_op(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 0, 1'b0);
      do_op(F3_MULH, 32'd0, 32'd5, 5'd1, 0, 1'b0);
      do_op(F3_MULHSU, 32'h80000000, 32'h7FFFFFFF, 5'd17, 5, 1'b0);
      // flush at RUN cycle 10
      issue(F3_MULL, 32'd11, 32'd13, 5'd4);
      repeat (9) tick();
      chk("pre_flush_en", {31'b0, mul_en_o}, 32'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_en", {31'b0, mul_en_o}, 32'd0);
      chk("flush_ready", {31'b0, req_ready_o}, 32'd1);
      chk("flush_busy", {31'b0, busy_o}, 32'd0);
      begin
         int v = 0;
         for (int i = 0; i < 40; i++) begin
            if (rsp_valid_o) v++;
            tick();
         end
         chk("flush_no_rsp", v, 0);
      end
      do_op(F3_MULL, 32'd11, 32'd13, 5'd4, 1, 1'b0);
      // flush drops a pending response
      issue(F3_MULL, 32'd0, 32'd9, 5'd2);
      chk("drop_valid", {31'b0, rsp_valid_o}, 32'd1);
      flush_i = 1'b1;
      rsp_ready_i = 1'b1;
      tick();
      flush_i = 1'b0;
      rsp_ready_i = 1'b0;
      chk("drop_idle", {31'b0, busy_o}, 32'd0);
      // asynchronous reset mid-RUN
      issue(F3_MULH, 32'd123, 32'd456, 5'd7);
      repeat (5) tick();
      rst = 1'b0;
      #1;
      chk("arst_en", {31'b0, mul_en_o}, 32'd0);
      chk("arst_ready", {31'b0, req_ready_o}, 32'd1);
      chk("arst_rd", {27'b0, rsp_rd_o}, 32'd0);
      chk("arst_a", mul_a_o, 32'd0);
      tick();
      rst = 1'b1;
      begin
         int v = 0;
         for (int i = 0; i < 40; i++) begin
            if (rsp_valid_o || busy_o) v++;
            tick();
         end
         chk("arst_no_rsp", v, 0);
      end
      do_op(F3_MULH, 32'd123, 32'd456, 5'd7, 0, 1'b1);
      for (int n = 0; n < 8; n++) begin
         logic [31:0] ra, rb;
         ra = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         do_op(3'($urandom_range(0, 3)), ra, rb, 5'($urandom), $urandom_range(0, 3), 1'b0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
